// File: rtl/axis_merger_pkg.sv
// Shared types and helpers for the 3-to-1 AXI-Stream merger.
// Imported by the merger top level.
package axis_merger_pkg;

    typedef enum logic [1:0] {
        S_PORT0,
        S_PORT1,
        S_PORT2
    } merger_state_t;

    // Beat counter width: enough bits to hold the larger per-port count.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/axis_register_slice.sv
// One-stage valid/ready register slice.
// Full throughput; data held stable while stalled.
module axis_register_slice #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    assign s_ready = !m_valid || m_ready;

    // Load on upstream handshake, empty on downstream-only handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (s_ready) begin
            m_valid <= s_valid;
            if (s_valid) begin
                m_data <= s_data;
            end
        end
    end

endmodule

// File: rtl/axis_merger.sv
// AXI-Stream 3-to-1 sequential merger.
// N0 beats from port 0, N1 from port 1, then port 2 forever.
module axis_merger
    import axis_merger_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int FROM_PORT_ZERO = 1,
    parameter int FROM_PORT_ONE  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  input_0_valid,
    output logic                  input_0_ready,
    input  logic [DATA_WIDTH-1:0] input_0_data,
    input  logic                  input_1_valid,
    output logic                  input_1_ready,
    input  logic [DATA_WIDTH-1:0] input_1_data,
    input  logic                  input_2_valid,
    output logic                  input_2_ready,
    input  logic [DATA_WIDTH-1:0] input_2_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [DATA_WIDTH-1:0] output_data
);

    localparam int CW = cnt_width(FROM_PORT_ZERO, FROM_PORT_ONE);
    localparam logic [CW-1:0] LAST0 = CW'(FROM_PORT_ZERO - 1);
    localparam logic [CW-1:0] LAST1 = CW'(FROM_PORT_ONE - 1);

    merger_state_t         state;
    logic [CW-1:0]         count;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  slice_ready;
    logic                  take;
    logic                  accept;

    // Route the selected input towards the output register.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        case (state)
            S_PORT0: begin
                sel_valid = input_0_valid;
                sel_data  = input_0_data;
            end
            S_PORT1: begin
                sel_valid = input_1_valid;
                sel_data  = input_1_data;
            end
            S_PORT2: begin
                sel_valid = input_2_valid;
                sel_data  = input_2_data;
            end
            default: begin
                sel_valid = 1'b0;
                sel_data  = '0;
            end
        endcase
    end

    // Readiness goes only to the selected port; clear and rst block intake.
    assign take   = slice_ready && !clear && !rst;
    assign accept = sel_valid && take;

    assign input_0_ready = take && (state == S_PORT0);
    assign input_1_ready = take && (state == S_PORT1);
    assign input_2_ready = take && (state == S_PORT2);

    // Sequence FSM and beat counter, advancing on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_PORT0;
            count <= '0;
        end else if (clear) begin
            state <= S_PORT0;
            count <= '0;
        end else if (accept) begin
            case (state)
                S_PORT0: begin
                    if (count == LAST0) begin
                        state <= S_PORT1;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_PORT1: begin
                    if (count == LAST1) begin
                        state <= S_PORT2;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_PORT2: begin
                    count <= '0;
                end
                default: begin
                    state <= S_PORT0;
                    count <= '0;
                end
            endcase
        end
    end

    axis_register_slice #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .s_valid(accept),
        .s_ready(slice_ready),
        .s_data (sel_data),
        .m_valid(output_valid),
        .m_ready(output_ready),
        .m_data (output_data)
    );

endmodule

// File: tb/tb_axis_merger.sv
// Randomized bench for axis_merger: two instances (17/17 and 1/1)
// checked every cycle against a beat-count reference model.
module tb_axis_merger;

    localparam int DW  = 16;
    localparam int P0A = 17;
    localparam int P1A = 17;
    localparam int P0B = 1;
    localparam int P1B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;

    logic          oready [2];
    logic          v      [2][3];
    logic [DW-1:0] gen    [2][3];
    logic          rdy    [2][3];
    logic          ov     [2];
    logic [DW-1:0] od     [2];

    int            taken  [2];
    logic          mv     [2];
    logic [DW-1:0] md     [2];
    int            pend   [2];
    logic          hold   [2];
    logic [DW-1:0] hold_d [2];

    logic [DW-1:0] log0[$];
    logic [DW-1:0] log1[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_merger #(
        .DATA_WIDTH(DW), .FROM_PORT_ZERO(P0A), .FROM_PORT_ONE(P1A)
    ) u_a (
        .clk(clk), .rst(rst), .clear(clear),
        .input_0_valid(v[0][0]), .input_0_ready(rdy[0][0]), .input_0_data(gen[0][0]),
        .input_1_valid(v[0][1]), .input_1_ready(rdy[0][1]), .input_1_data(gen[0][1]),
        .input_2_valid(v[0][2]), .input_2_ready(rdy[0][2]), .input_2_data(gen[0][2]),
        .output_valid(ov[0]), .output_ready(oready[0]), .output_data(od[0])
    );

    axis_merger #(
        .DATA_WIDTH(DW), .FROM_PORT_ZERO(P0B), .FROM_PORT_ONE(P1B)
    ) u_b (
        .clk(clk), .rst(rst), .clear(clear),
        .input_0_valid(v[1][0]), .input_0_ready(rdy[1][0]), .input_0_data(gen[1][0]),
        .input_1_valid(v[1][1]), .input_1_ready(rdy[1][1]), .input_1_data(gen[1][1]),
        .input_2_valid(v[1][2]), .input_2_ready(rdy[1][2]), .input_2_data(gen[1][2]),
        .output_valid(ov[1]), .output_ready(oready[1]), .output_data(od[1])
    );

    task automatic chk(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    // Which port owns the n-th beat since the last restart.
    function automatic int port_of(input int k, input int t);
        int n0;
        int n1;
        n0 = (k == 0) ? P0A : P0B;
        n1 = (k == 0) ? P1A : P1B;
        if (t < n0) return 0;
        if (t < n0 + n1) return 1;
        return 2;
    endfunction

    // One clock cycle: drive, check against model, advance model.
    task automatic cycle(input int pv, input int pr, input bit clr, input bit r);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (pend[k] >= 0) begin
                gen[k][pend[k]] = gen[k][pend[k]] + 1'b1;
                v[k][pend[k]] = 1'b0;
                pend[k] = -1;
            end
        end
        clear = clr;
        rst = r;
        for (int k = 0; k < 2; k++) begin
            oready[k] = ($urandom_range(99) < pr);
            for (int p = 0; p < 3; p++) begin
                if (!v[k][p]) v[k][p] = ($urandom_range(99) < pv);
            end
            if (r) begin
                mv[k] = 1'b0;
                md[k] = '0;
                taken[k] = 0;
                hold[k] = 1'b0;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            int  sel;
            bit  open;
            sel  = port_of(k, taken[k]);
            open = !r && !clr && (!mv[k] || oready[k]);
            chk("out_valid", k, int'(ov[k]), int'(mv[k]));
            chk("out_data", k, int'(od[k]), int'(md[k]));
            if (hold[k]) chk("stable", k, int'(od[k]), int'(hold_d[k]));
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("ready%0d", p), k, int'(rdy[k][p]), int'(open && sel == p));
            end
            if (ov[k] && oready[k]) begin
                if (k == 0) log0.push_back(od[k]);
                else        log1.push_back(od[k]);
            end
            hold[k]   = ov[k] && !oready[k];
            hold_d[k] = od[k];
            if (open && v[k][sel]) begin
                md[k] = gen[k][sel];
                mv[k] = 1'b1;
                taken[k]++;
                pend[k] = sel;
            end else if (oready[k]) begin
                mv[k] = 1'b0;
            end
            if (clr && !r) taken[k] = 0;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            oready[k] = 1'b1;
            mv[k] = 1'b0;
            md[k] = '0;
            taken[k] = 0;
            pend[k] = -1;
            hold[k] = 1'b0;
            hold_d[k] = '0;
            for (int p = 0; p < 3; p++) begin
                v[k][p] = 1'b0;
                gen[k][p] = (p == 0) ? DW'(512) : '0;
            end
        end

        repeat (3) cycle(100, 100, 1'b0, 1'b1);

        // Continuous flow, two-cycle clear pulse at cycle 256.
        for (int i = 0; i < 400; i++) begin
            cycle(100, 100, (i == 256 || i == 257), 1'b0);
        end

        // Literal pins on the first sequences.
        if (log0.size() < 50 || log1.size() < 4) begin
            chk("log_size", 0, log0.size(), 50);
        end else begin
            chk("lit0_first", 0, int'(log0[0]), 512);
            chk("lit0_last_p0", 0, int'(log0[16]), 528);
            chk("lit0_first_p1", 0, int'(log0[17]), 0);
            chk("lit0_last_p1", 0, int'(log0[33]), 16);
            chk("lit0_first_p2", 0, int'(log0[34]), 0);
            chk("lit0_p2_6", 0, int'(log0[40]), 6);
            chk("lit1_p0", 1, int'(log1[0]), 512);
            chk("lit1_p1", 1, int'(log1[1]), 0);
            chk("lit1_p2_0", 1, int'(log1[2]), 0);
            chk("lit1_p2_1", 1, int'(log1[3]), 1);
        end

        // Random backpressure.
        repeat (2) cycle(100, 100, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) cycle(100, 50, 1'b0, 1'b0);

        // Random source gaps plus backpressure, with a mid-run clear.
        repeat (2) cycle(60, 50, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) cycle(60, 50, (i == 150), 1'b0);

        // Fill the output register, stall, then reset mid-stream.
        for (int i = 0; i < 5; i++) cycle(100, 100, 1'b0, 1'b0);
        cycle(100, 0, 1'b0, 1'b0);
        cycle(100, 0, 1'b0, 1'b0);
        chk("full_before_rst", 0, int'(ov[0]), 1);
        cycle(100, 0, 1'b0, 1'b1);
        chk("rst_valid", 0, int'(ov[0]), 0);
        chk("rst_ready0", 0, int'(rdy[0][0] | rdy[0][1] | rdy[0][2]), 0);
        for (int i = 0; i < 100; i++) cycle(100, 70, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
